// File: rtl/target_power_sequencer.sv
// -----------------------------------------------------------------------------
// target_power_sequencer
//
// Sequences the target power switch and the target nRST line so the host can
// request a clean power cycle (power off, settle, reset hold, release) or a
// reset-only pulse. Shares the register bus with the other capture/glitch
// register blocks; read data is zero whenever this block is not addressed, so
// it can be ORed onto the common read bus.
//
// Optional feature (compile-time macro):
//   TPS_EXT_START_EN - ext_start_i is synchronised (2 flops) and its rising
//                      edge acts as a START. When undefined, ext_start_i is
//                      ignored.
//
// Ports:
//   clk_usb         buffered USB clock
//   reset_n         asynchronous active-low reset
//   reg_address     register address
//   reg_bytecnt     byte index within the addressed register
//   reg_datai       write data
//   reg_datao       read data, 0 when not addressed
//   reg_read        read strobe
//   reg_write       write strobe
//   reg_addrvalid   address valid qualifier
//   reg_hyplen      byte length of the register at reg_hypaddress
//   reg_hypaddress  length-query address
//   ext_start_i     external start request
//   targetpower_off 1 = target power switched off
//   nrst_en         1 = drive target nRST
//   nrst_o          nRST drive value
//   busy            sequence in progress
//   done_o          one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module target_power_sequencer #(
  parameter logic [5:0] ADDR_CTRL   = 6'd60,
  parameter logic [5:0] ADDR_TIMING = 6'd61,
  parameter int         PRESCALE    = 96000,
  parameter int         PRESCALE_W  = 17
) (
  input  logic        clk_usb,
  input  logic        reset_n,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  output logic [15:0] reg_hyplen,
  input  logic [5:0]  reg_hypaddress,
  input  logic        ext_start_i,
  output logic        targetpower_off,
  output logic        nrst_en,
  output logic        nrst_o,
  output logic        busy,
  output logic        done_o
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PWR_OFF  = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_RST_HOLD = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [2:0]            state, nxt;
  logic [7:0]            t_off, t_settle, t_rst;
  logic [7:0]            sh_off, sh_settle, sh_rst;
  logic                  manual_off, rst_only, done_flag;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [7:0]            unit_cnt;

  logic       wr_en, ctrl_wr, tim_wr;
  logic       ext_edge, start_req, abort_req;
  logic       rst_only_nxt, manual_off_nxt;
  logic [7:0] timer_n;
  logic       pre_term, timer_done, seq_done;
  logic       off_nxt, en_nxt, o_nxt;

  // ---------------------------------------------------------------------------
  // External start
  // ---------------------------------------------------------------------------
`ifdef TPS_EXT_START_EN
  // Two synchroniser flops plus one history flop for edge detection: the edge
  // is seen two edges after the input rises and the sequencer moves on the
  // third.
  logic [2:0] ext_sync;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) ext_sync <= '0;
    else          ext_sync <= {ext_sync[1:0], ext_start_i};
  end

  assign ext_edge = ext_sync[1] & ~ext_sync[2];
`else
  logic ext_start_unused;
  assign ext_start_unused = ext_start_i;
  assign ext_edge         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write decode and sequencing requests
  // ---------------------------------------------------------------------------
  assign wr_en   = reg_write & reg_addrvalid;
  assign ctrl_wr = wr_en && (reg_address == ADDR_CTRL);
  assign tim_wr  = wr_en && (reg_address == ADDR_TIMING);

  // A CTRL write carrying START uses the RST_ONLY bit of that same write.
  assign rst_only_nxt   = ctrl_wr ? reg_datai[3] : rst_only;
  assign manual_off_nxt = ctrl_wr ? reg_datai[2] : manual_off;

  assign start_req = (ctrl_wr && reg_datai[0]) || ext_edge;
  // Turning the power off by hand in the middle of a sequence cancels it.
  assign abort_req = ctrl_wr && (reg_datai[1] || (reg_datai[2] && (state != ST_IDLE)));

  // ---------------------------------------------------------------------------
  // Timed-state length: N units of PRESCALE cycles, N = 0 lasts one cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    timer_n = 8'd0;
    case (state)
      ST_PWR_OFF:  timer_n = sh_off;
      ST_SETTLE:   timer_n = sh_settle;
      ST_RST_HOLD: timer_n = sh_rst;
      default:     timer_n = 8'd0;
    endcase
  end

  assign pre_term   = (pre_cnt == PRE_LAST);
  assign timer_done = (timer_n == 8'd0) || (pre_term && (unit_cnt == timer_n - 8'd1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt = state;
    if (abort_req) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (start_req) nxt = rst_only_nxt ? ST_RST_HOLD : ST_PWR_OFF;
        ST_PWR_OFF:  if (timer_done) nxt = ST_SETTLE;
        ST_SETTLE:   if (timer_done) nxt = ST_RST_HOLD;
        ST_RST_HOLD: if (timer_done) nxt = ST_RELEASE;
        ST_RELEASE:  nxt = ST_IDLE;
        default:     nxt = ST_IDLE;
      endcase
    end
  end

  assign seq_done = (state == ST_RELEASE) && (nxt == ST_IDLE);

  // Pin values are decoded from the next state and registered, so they change
  // together with the state and never glitch.
  always_comb begin
    off_nxt = 1'b0;
    en_nxt  = 1'b1;
    o_nxt   = 1'b0;
    case (nxt)
      ST_IDLE: begin
        off_nxt = manual_off_nxt;
        en_nxt  = 1'b0;
        o_nxt   = 1'b1;
      end
      ST_PWR_OFF:  off_nxt = 1'b1;
      ST_RELEASE:  o_nxt   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer state, counters and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_usb or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state           <= ST_IDLE;
      pre_cnt         <= '0;
      unit_cnt        <= 8'd0;
      sh_off          <= 8'd100;
      sh_settle       <= 8'd10;
      sh_rst          <= 8'd5;
      targetpower_off <= 1'b0;
      nrst_en         <= 1'b0;
      nrst_o          <= 1'b1;
      busy            <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      state           <= nxt;
      targetpower_off <= off_nxt;
      nrst_en         <= en_nxt;
      nrst_o          <= o_nxt;
      busy            <= (nxt != ST_IDLE);
      done_o          <= seq_done;

      // Counters restart on every state entry.
      if (nxt != state) begin
        pre_cnt  <= '0;
        unit_cnt <= 8'd0;
      end else if (state != ST_IDLE) begin
        if (pre_term) begin
          pre_cnt  <= '0;
          unit_cnt <= unit_cnt + 8'd1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      // Shadow copies freeze the timing for the whole sequence.
      if ((state == ST_IDLE) && (nxt != ST_IDLE)) begin
        sh_off    <= t_off;
        sh_settle <= t_settle;
        sh_rst    <= t_rst;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Host-visible registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      manual_off <= 1'b0;
      rst_only   <= 1'b0;
      done_flag  <= 1'b0;
      t_off      <= 8'd100;
      t_settle   <= 8'd10;
      t_rst      <= 8'd5;
    end else begin
      if (ctrl_wr) begin
        manual_off <= reg_datai[2];
        rst_only   <= reg_datai[3];
      end

      // A completion in the same cycle as a clear keeps DONE set.
      if (seq_done)                        done_flag <= 1'b1;
      else if (ctrl_wr && reg_datai[4])    done_flag <= 1'b0;

      if (tim_wr) begin
        case (reg_bytecnt)
          16'd0:   t_off    <= reg_datai;
          16'd1:   t_settle <= reg_datai;
          16'd2:   t_rst    <= reg_datai;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data and register length
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_datao = 8'd0;
    if (reg_addrvalid && reg_read) begin
      if (reg_address == ADDR_CTRL) begin
        reg_datao = {2'b00, manual_off, done_flag, state, busy};
      end else if (reg_address == ADDR_TIMING) begin
        case (reg_bytecnt)
          16'd0:   reg_datao = t_off;
          16'd1:   reg_datao = t_settle;
          16'd2:   reg_datao = t_rst;
          default: reg_datao = 8'd0;
        endcase
      end
    end
  end

  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == ADDR_CTRL)        reg_hyplen = 16'd1;
    else if (reg_hypaddress == ADDR_TIMING) reg_hyplen = 16'd3;
  end

endmodule

// File: tb/tb_target_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_target_power_sequencer
//
// Self-checking bench for target_power_sequencer with PRESCALE = 4. A table of
// register-bus vectors covers reset values, decode and simple writes; directed
// sequences cover the full power cycle, reset-only, abort, shadowed timing,
// asynchronous reset and the external start input.
// -----------------------------------------------------------------------------
module tb_target_power_sequencer;

  localparam logic [5:0] A_CTRL = 6'd60;
  localparam logic [5:0] A_TIM  = 6'd61;

  logic        clk_usb = 1'b0;
  logic        reset_n;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [15:0] reg_hyplen;
  logic [5:0]  reg_hypaddress;
  logic        ext_start_i;
  logic        targetpower_off;
  logic        nrst_en;
  logic        nrst_o;
  logic        busy;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_usb = ~clk_usb;

  target_power_sequencer #(
    .ADDR_CTRL  (A_CTRL),
    .ADDR_TIMING(A_TIM),
    .PRESCALE   (4),
    .PRESCALE_W (17)
  ) dut (
    .clk_usb        (clk_usb),
    .reset_n        (reset_n),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hyplen     (reg_hyplen),
    .reg_hypaddress (reg_hypaddress),
    .ext_start_i    (ext_start_i),
    .targetpower_off(targetpower_off),
    .nrst_en        (nrst_en),
    .nrst_o         (nrst_o),
    .busy           (busy),
    .done_o         (done_o)
  );

  typedef struct packed {
    logic        wr;
    logic        av;
    logic [5:0]  addr;
    logic [15:0] bc;
    logic [7:0]  data;
    logic [7:0]  exp_do;
    logic [15:0] exp_hyp;
    logic        exp_off;
  } vec_t;

  // Status word: {busy, targetpower_off, nrst_en, nrst_o, done_o}
  localparam logic [4:0] S_IDLE  = 5'b00010;
  localparam logic [4:0] S_DONE  = 5'b00011;
  localparam logic [4:0] S_OFF   = 5'b11100;
  localparam logic [4:0] S_HOLD  = 5'b10100;
  localparam logic [4:0] S_REL   = 5'b10110;

  function automatic logic [4:0] status();
    return {busy, targetpower_off, nrst_en, nrst_o, done_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [15:0] bc, input logic [7:0] data);
    reg_address   = addr;
    reg_bytecnt   = bc;
    reg_datai     = data;
    reg_addrvalid = 1'b1;
    reg_write     = 1'b1;
    @(posedge clk_usb);
    #1;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] addr, input logic [15:0] bc, output logic [7:0] data);
    reg_address   = addr;
    reg_bytecnt   = bc;
    reg_addrvalid = 1'b1;
    reg_read      = 1'b1;
    #1;
    data          = reg_datao;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  // Counts negedges until done_o is seen; -1 if the bound runs out.
  task automatic wait_done(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk_usb);
      if (done_o) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    vec_t       vecs[12];
    logic [4:0] exp_st;
    logic [7:0] rd;
    int         n;
    logic       seen;

    vecs[0]  = '{wr:1'b0, av:1'b1, addr:A_CTRL, bc:16'd0, data:8'h00, exp_do:8'h00, exp_hyp:16'd1, exp_off:1'b0};
    vecs[1]  = '{wr:1'b0, av:1'b1, addr:A_TIM,  bc:16'd0, data:8'h00, exp_do:8'd100, exp_hyp:16'd3, exp_off:1'b0};
    vecs[2]  = '{wr:1'b0, av:1'b1, addr:A_TIM,  bc:16'd1, data:8'h00, exp_do:8'd10,  exp_hyp:16'd3, exp_off:1'b0};
    vecs[3]  = '{wr:1'b0, av:1'b1, addr:A_TIM,  bc:16'd2, data:8'h00, exp_do:8'd5,   exp_hyp:16'd3, exp_off:1'b0};
    vecs[4]  = '{wr:1'b0, av:1'b1, addr:A_TIM,  bc:16'd3, data:8'h00, exp_do:8'd0,   exp_hyp:16'd3, exp_off:1'b0};
    vecs[5]  = '{wr:1'b0, av:1'b1, addr:6'd5,   bc:16'd0, data:8'h00, exp_do:8'd0,   exp_hyp:16'd0, exp_off:1'b0};
    vecs[6]  = '{wr:1'b0, av:1'b0, addr:A_TIM,  bc:16'd0, data:8'h00, exp_do:8'd0,   exp_hyp:16'd3, exp_off:1'b0};
    vecs[7]  = '{wr:1'b1, av:1'b1, addr:A_CTRL, bc:16'd0, data:8'h04, exp_do:8'h20, exp_hyp:16'd1, exp_off:1'b1};
    vecs[8]  = '{wr:1'b1, av:1'b1, addr:A_CTRL, bc:16'd0, data:8'h00, exp_do:8'h00, exp_hyp:16'd1, exp_off:1'b0};
    vecs[9]  = '{wr:1'b1, av:1'b1, addr:A_TIM,  bc:16'd0, data:8'd2,  exp_do:8'd2,  exp_hyp:16'd3, exp_off:1'b0};
    vecs[10] = '{wr:1'b1, av:1'b1, addr:A_TIM,  bc:16'd1, data:8'd1,  exp_do:8'd1,  exp_hyp:16'd3, exp_off:1'b0};
    vecs[11] = '{wr:1'b1, av:1'b1, addr:A_TIM,  bc:16'd2, data:8'd3,  exp_do:8'd3,  exp_hyp:16'd3, exp_off:1'b0};

    reset_n        = 1'b0;
    reg_address    = A_CTRL;
    reg_bytecnt    = 16'd0;
    reg_datai      = 8'd0;
    reg_read       = 1'b1;
    reg_write      = 1'b0;
    reg_addrvalid  = 1'b1;
    reg_hypaddress = A_CTRL;
    ext_start_i    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_usb);
    check("reset_status", 32'(status()), 32'(S_IDLE));
    check("reset_datao", 32'(reg_datao), 32'h0);
    reset_n = 1'b1;
    @(negedge clk_usb);

    // Register-bus vector table
    for (int i = 0; i < 12; i++) begin
      reg_address    = vecs[i].addr;
      reg_bytecnt    = vecs[i].bc;
      reg_datai      = vecs[i].data;
      reg_hypaddress = vecs[i].addr;
      reg_addrvalid  = vecs[i].av;
      reg_read       = 1'b1;
      if (vecs[i].wr) begin
        reg_write = 1'b1;
        @(posedge clk_usb);
        #1;
        reg_write = 1'b0;
      end
      @(negedge clk_usb);
      check($sformatf("vec%0d_datao", i), 32'(reg_datao), 32'(vecs[i].exp_do));
      check($sformatf("vec%0d_hyplen", i), 32'(reg_hyplen), 32'(vecs[i].exp_hyp));
      check($sformatf("vec%0d_off", i), 32'(targetpower_off), 32'(vecs[i].exp_off));
    end
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;

    // Full power cycle, timing {2,1,3}, PRESCALE 4
    bus_write(A_CTRL, 16'd0, 8'h01);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk_usb);
      if (k <= 8)       exp_st = S_OFF;
      else if (k <= 24) exp_st = S_HOLD;
      else if (k == 25) exp_st = S_REL;
      else if (k == 26) exp_st = S_DONE;
      else              exp_st = S_IDLE;
      check($sformatf("cycle_c%0d", k), 32'(status()), 32'(exp_st));
    end
    bus_read(A_CTRL, 16'd0, rd);
    check("done_sticky", 32'(rd), 32'h10);
    bus_write(A_CTRL, 16'd0, 8'h10);
    bus_read(A_CTRL, 16'd0, rd);
    check("done_cleared", 32'(rd), 32'h00);

    // Reset-only pulse with t_rst = 0
    bus_write(A_TIM, 16'd2, 8'd0);
    bus_write(A_CTRL, 16'd0, 8'h09);
    @(negedge clk_usb);
    check("rstonly_hold", 32'(status()), 32'(S_HOLD));
    bus_read(A_CTRL, 16'd0, rd);
    check("rstonly_code", 32'(rd), 32'h07);
    @(negedge clk_usb);
    check("rstonly_release", 32'(status()), 32'(S_REL));
    @(negedge clk_usb);
    check("rstonly_done", 32'(status()), 32'(S_DONE));
    bus_write(A_CTRL, 16'd0, 8'h10);

    // Abort during SETTLE
    bus_write(A_TIM, 16'd2, 8'd3);
    bus_write(A_CTRL, 16'd0, 8'h01);
    repeat (10) @(negedge clk_usb);
    bus_read(A_CTRL, 16'd0, rd);
    check("abort_in_settle", 32'(rd), 32'h05);
    bus_write(A_CTRL, 16'd0, 8'h02);
    @(negedge clk_usb);
    check("abort_idle", 32'(status()), 32'(S_IDLE));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_usb);
      if (done_o) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    bus_read(A_CTRL, 16'd0, rd);
    check("abort_done_flag", 32'(rd), 32'h00);

    // Timing write while busy affects only the next sequence
    bus_write(A_CTRL, 16'd0, 8'h01);
    repeat (2) @(negedge clk_usb);
    bus_write(A_TIM, 16'd0, 8'd50);
    wait_done(200, n);
    check("shadow_old_len", 32'(n), 32'd24);
    bus_read(A_TIM, 16'd0, rd);
    check("live_toff", 32'(rd), 32'd50);
    bus_write(A_CTRL, 16'd0, 8'h11);
    wait_done(1000, n);
    check("shadow_new_len", 32'(n), 32'd218);

    // Asynchronous reset during PWR_OFF
    bus_write(A_TIM, 16'd0, 8'd2);
    bus_write(A_CTRL, 16'd0, 8'h01);
    repeat (3) @(negedge clk_usb);
    check("pre_reset_off", 32'(status()), 32'(S_OFF));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 32'(status()), 32'(S_IDLE));
    @(negedge clk_usb);
    reset_n = 1'b1;
    bus_read(A_TIM, 16'd0, rd);
    check("reset_toff", 32'(rd), 32'd100);
    bus_read(A_TIM, 16'd1, rd);
    check("reset_tsettle", 32'(rd), 32'd10);
    bus_read(A_TIM, 16'd2, rd);
    check("reset_trst", 32'(rd), 32'd5);
    bus_read(A_CTRL, 16'd0, rd);
    check("reset_ctrl", 32'(rd), 32'h00);

`ifdef TPS_EXT_START_EN
    // External start: three-cycle latency, second edge while busy ignored
    bus_write(A_TIM, 16'd0, 8'd2);
    bus_write(A_TIM, 16'd1, 8'd1);
    bus_write(A_TIM, 16'd2, 8'd3);
    @(negedge clk_usb);
    ext_start_i = 1'b1;
    @(negedge clk_usb);
    check("ext_c1", 32'(status()), 32'(S_IDLE));
    @(negedge clk_usb);
    check("ext_c2", 32'(status()), 32'(S_IDLE));
    @(negedge clk_usb);
    check("ext_c3", 32'(status()), 32'(S_OFF));
    @(negedge clk_usb);
    ext_start_i = 1'b0;
    repeat (2) @(negedge clk_usb);
    ext_start_i = 1'b1;
    wait_done(200, n);
    check("ext_len", 32'(n), 32'd22);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_usb);
      if (busy) seen = 1'b1;
    end
    check("ext_second_ignored", 32'(seen), 32'h0);
    ext_start_i = 1'b0;
`else
    // Without the feature the input has no effect
    @(negedge clk_usb);
    ext_start_i = 1'b1;
    repeat (5) @(negedge clk_usb);
    check("ext_ignored", 32'(status()), 32'(S_IDLE));
    ext_start_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/target_power_sequencer.md
# target_power_sequencer

Sequences the target power switch and target nRST line for a clean target power cycle or reset pulse. Sits on the shared register bus beside the ChipWhisperer and clock-glitch register blocks, and ORs its read data into the common read bus. Its outputs drive `target_npower` and the `target_nRST` tri-state enable and value at the top level. It runs from the buffered USB clock.

## Interface
Parameters:
- ADDR_CTRL, 6'd60, address of control/status register (1 byte)
- ADDR_TIMING, 6'd61, address of timing register (3 bytes: off, settle, reset)
- PRESCALE, 96000, clk_usb cycles per timing unit (1 ms at 96 MHz); must be ≥1
- PRESCALE_W, 17, prescaler counter width

Ports:
- clk_usb  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- reg_address  in  6  register address
- reg_bytecnt  in  16  byte index within register
- reg_datai  in  8  write data
- reg_datao  out  8  read data; 0 when not addressed
- reg_read  in  1  read strobe
- reg_write  in  1  write strobe
- reg_addrvalid  in  1  address valid
- reg_hyplen  out  16  register length for reg_hypaddress
- reg_hypaddress  in  6  length-query address
- ext_start_i  in  1  external start request (see Configuration)
- targetpower_off  out  1  1 = target power switched off
- nrst_en  out  1  1 = drive target nRST
- nrst_o  out  1  nRST drive value
- busy  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when a sequence completes

## Operation
CTRL write:
- bit0 START: self-clearing.
- bit1 ABORT: self-clearing.
- bit2 MANUAL_OFF: level.
- bit3 RST_ONLY: level; skip the power phases.

CTRL read:
- bit0 busy.
- bits[3:1] state code.
- bit4 DONE: sticky; cleared by a write with bit4 = 1.
- bit5 MANUAL_OFF.

TIMING register:
- bytecnt 0 = t_off, 1 = t_settle, 2 = t_rst. Units are PRESCALE cycles.
- Reset values: 100, 10, 5.
- At START, all three values are latched into shadow registers. A write during busy updates only the live registers.

States and codes:
- IDLE(0): busy = 0.
- PWR_OFF(1): targetpower_off = 1, nrst_en = 1, nrst_o = 0.
- SETTLE(2): power on, nrst_en = 1, nrst_o = 0.
- RST_HOLD(3): power on, nrst_en = 1, nrst_o = 0.
- RELEASE(4): one cycle, nrst_en = 1, nrst_o = 1. Then go to IDLE, pulse done_o and set DONE.

Transitions:
- START in IDLE with RST_ONLY = 0 → PWR_OFF. With RST_ONLY = 1 → RST_HOLD.
- Each timed state lasts max(1, N·PRESCALE) cycles. N is the shadow value. Prescaler and unit counter clear on state entry.
- ABORT in any state → IDLE next cycle. No done_o pulse, DONE unchanged.
- START and ABORT in the same write: ABORT wins.
- START while busy is ignored.
- Setting MANUAL_OFF while busy aborts the sequence.

Outputs in IDLE:
- targetpower_off = MANUAL_OFF.
- nrst_en = 0 (nRST floats), nrst_o = 1.

Register bus:
- reg_hyplen = 1 for ADDR_CTRL, 3 for ADDR_TIMING, 0 otherwise.
- reg_datao = 0 unless reg_addrvalid and reg_read are asserted on an owned address.

## Timing
- Reset (reset_n low, async) clears everything immediately:
  - state = IDLE, all outputs 0 except nrst_o = 1; reg_datao 0, busy 0, done_o 0.
  - Registers return to default values; MANUAL_OFF = 0, DONE = 0.
- Reset mid-sequence returns to IDLE with the same values, without a done_o pulse.
- Writes:
  - A write is accepted on the cycle reg_write and reg_addrvalid are high.
  - The state change is visible on the next clk_usb edge.
  - START → first PWR_OFF output on cycle +1.
- Read data is combinational from address, strobes and current registers: zero-latency.
- Full sequence length: 1 + (t_off + t_settle + t_rst)·PRESCALE + 1 cycles from the START write to done_o.
  - Zero values count as 1 cycle each.
- Counter widths:
  - Unit counter is 8 bits, so t = 255 is the maximum; no wrap is possible.
  - Prescaler terminal is PRESCALE−1.
- Outputs are registered: no glitches on targetpower_off, nrst_en or nrst_o.

## Configuration
- TPS_EXT_START_EN defined:
  - ext_start_i is synchronised through 2 flops and rising-edge detected.
  - The edge acts as a START with RST_ONLY taken from CTRL.
  - Edge-to-first-state latency is 3 cycles.
  - An edge while busy is ignored. A simultaneous ABORT write wins.
- Undefined: ext_start_i is ignored (port remains, no logic).

## Test plan
- PRESCALE = 4, TIMING = {2,1,3}, write CTRL = 0x01:
  - targetpower_off high for 8 cycles, then nrst driven low 16 cycles, then 1 release cycle.
  - done_o pulses at cycle 26; DONE reads 1.
- RST_ONLY = 1, t_rst = 0, START:
  - RST_HOLD for 1 cycle, RELEASE, done_o.
  - targetpower_off never asserts.
- Start a sequence, write ABORT during SETTLE:
  - IDLE next cycle, nrst_en = 0, no done_o pulse, DONE unchanged.
- Write TIMING t_off = 50 while busy:
  - Current sequence still uses the old value.
  - The next START uses 50.
- Assert reset_n low during PWR_OFF:
  - targetpower_off 0, nrst_en 0 and busy 0 immediately, before the next clock edge.
  - After release, TIMING reads back 100/10/5.
- With TPS_EXT_START_EN, rising edge on ext_start_i:
  - PWR_OFF at +3 cycles.
  - A second edge while busy is ignored.
